// File: rtl/conv_layer_sequencer.sv
// conv_layer_sequencer: per-layer scheduler for weight fill, data fill, array compute and output drain.
// Optional watchdog and ERR state are built when SEQ_TIMEOUT_EN is defined.
module conv_layer_sequencer #(
    parameter int dim_data_size = 16,
    parameter int addr_width    = 15,
    parameter int array_size    = 9,
    parameter int max_layers    = 4,
    localparam int lw = $clog2(max_layers),
    localparam int cw = 2 * dim_data_size
) (
    input  logic                     clk,
    input  logic                     reset,
    input  logic                     cfg_we,
    input  logic [lw-1:0]            cfg_layer,
    input  logic [addr_width-1:0]    cfg_weight_addr,
    input  logic [dim_data_size-1:0] cfg_weight_size,
    input  logic [dim_data_size-1:0] cfg_filters,
    input  logic [dim_data_size-1:0] cfg_input_size,
    input  logic [lw:0]              num_layers,
    input  logic                     start,
    output logic                     sub_reset_n,
    output logic                     wf_enable,
    input  logic                     wf_done,
    output logic [addr_width-1:0]    wf_initial_address,
    output logic [dim_data_size-1:0] wf_weight_size,
    output logic [dim_data_size-1:0] wf_number_filters,
    output logic                     df_enable,
    input  logic                     df_done,
    output logic                     array_enable,
    output logic                     od_enable,
    input  logic                     od_done,
    output logic [lw-1:0]            layer_idx,
    output logic                     busy,
    output logic                     all_done,
    output logic                     error
);
    typedef enum logic [3:0] {
        IDLE, SUB_RST, WF_RUN, DF_RUN, COMPUTE, DRAIN, NEXT, DONE
`ifdef SEQ_TIMEOUT_EN
        , ERR
`endif
    } state_t;

    state_t                  state_q, state_d;
    logic [lw-1:0]           layer_q, layer_d;
    logic [lw:0]             count_q;
    logic [cw-1:0]           cnt_q, side, c_val;
    logic [addr_width-1:0]   tab_addr_q [max_layers];
    logic [dim_data_size-1:0] tab_k_q [max_layers];
    logic [dim_data_size-1:0] tab_f_q [max_layers];
    logic [dim_data_size-1:0] tab_n_q [max_layers];
    logic [addr_width-1:0]   addr_q;
    logic [dim_data_size-1:0] k_q, f_q, n_q;
    logic                    srst_q, wf_en_q, df_en_q, ar_en_q, od_en_q, busy_q, done_q, skip;

    // N >= K is guaranteed once a layer is not skipped, so the subtraction cannot wrap
    assign side  = cw'(n_q - k_q) + cw'(1);
    assign c_val = side * side + cw'(2 * array_size - 2);
    assign skip  = (tab_k_q[layer_q] == '0) || (tab_f_q[layer_q] == '0) || (tab_n_q[layer_q] < tab_k_q[layer_q]);

`ifdef SEQ_TIMEOUT_EN
    logic [19:0] wd_q;
    logic        err_q, watched;
    assign watched = (state_q == WF_RUN) || (state_q == DF_RUN) || (state_q == DRAIN);
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            wd_q  <= '0;
            err_q <= 1'b0;
        end else begin
            wd_q  <= (state_d != state_q || !watched) ? '0 : wd_q + 20'd1;
            err_q <= err_q | (state_d == ERR);
        end
    end
    assign error = err_q;
`else
    assign error = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        layer_d = layer_q;
        case (state_q)
            IDLE: if (start) begin
                // a zero-layer run passes through NEXT, which falls straight to DONE
                state_d = (num_layers == '0) ? NEXT : SUB_RST;
                layer_d = '0;
            end
            SUB_RST: state_d = skip ? NEXT : WF_RUN;
            WF_RUN:  state_d = wf_done ? DF_RUN : WF_RUN;
            DF_RUN:  state_d = df_done ? COMPUTE : DF_RUN;
            COMPUTE: state_d = (cnt_q == '0) ? DRAIN : COMPUTE;
            DRAIN:   state_d = od_done ? NEXT : DRAIN;
            NEXT: if (({1'b0, layer_q} + (lw+1)'(1)) < count_q) begin
                state_d = SUB_RST;
                layer_d = layer_q + lw'(1);
            end else begin
                state_d = DONE;
            end
            DONE:    state_d = IDLE;
            default: state_d = state_q;
        endcase
`ifdef SEQ_TIMEOUT_EN
        if (watched && wd_q == '1) state_d = ERR;
`endif
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            layer_q <= '0;
            count_q <= '0;
            cnt_q   <= '0;
            addr_q  <= '0;
            k_q     <= '0;
            f_q     <= '0;
            n_q     <= '0;
            srst_q  <= 1'b1;
            wf_en_q <= 1'b0;
            df_en_q <= 1'b0;
            ar_en_q <= 1'b0;
            od_en_q <= 1'b0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
            for (int i = 0; i < max_layers; i++) begin
                tab_addr_q[i] <= '0;
                tab_k_q[i]    <= '0;
                tab_f_q[i]    <= '0;
                tab_n_q[i]    <= '0;
            end
        end else begin
            state_q <= state_d;
            layer_q <= layer_d;
            if (state_q == IDLE && start) count_q <= num_layers;
            if (state_q == IDLE && cfg_we) begin
                tab_addr_q[cfg_layer] <= cfg_weight_addr;
                tab_k_q[cfg_layer]    <= cfg_weight_size;
                tab_f_q[cfg_layer]    <= cfg_filters;
                tab_n_q[cfg_layer]    <= cfg_input_size;
            end
            if (state_q == SUB_RST) begin
                addr_q <= tab_addr_q[layer_q];
                k_q    <= tab_k_q[layer_q];
                f_q    <= tab_f_q[layer_q];
                n_q    <= tab_n_q[layer_q];
            end
            cnt_q   <= (state_q == COMPUTE) ? cnt_q - cw'(1) : c_val - cw'(1);
            srst_q  <= state_d != SUB_RST;
            wf_en_q <= state_d == WF_RUN;
            df_en_q <= state_d == DF_RUN;
            ar_en_q <= state_d == COMPUTE;
            od_en_q <= state_d == DRAIN;
            busy_q  <= state_d != IDLE;
            done_q  <= state_d == DONE;
        end
    end

    assign sub_reset_n        = srst_q;
    assign wf_enable          = wf_en_q;
    assign df_enable          = df_en_q;
    assign array_enable       = ar_en_q;
    assign od_enable          = od_en_q;
    assign busy               = busy_q;
    assign all_done           = done_q;
    assign layer_idx          = layer_q;
    assign wf_initial_address = addr_q;
    assign wf_weight_size     = k_q;
    assign wf_number_filters  = f_q;
endmodule
